spi_slave_if: RTL and testbench



---
 rtl/spi_slave_pkg.sv | 21 ++
 rtl/spi_slave_if_if.sv | 35 +++
 rtl/spi_slave_if.sv | 114 +++++++++++
 tb/tb_spi_slave_if.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave front end of the byte RAM.
package spi_slave_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  // Command field carried in the two MSBs of every frame
  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  // Bits per frame after the selector bit: two cmd bits plus one payload byte
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/spi_slave_if_if.sv
// Bundle of SPI pins and RAM-side command/response signals.
// The slave modport is the serial front end; master is the side that drives it.
interface spi_slave_if_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  SS_n;
  logic                  MOSI;
  logic                  MISO;
  logic [DATA_WIDTH+1:0] rx_data;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;

  modport slave (
    input  SS_n,
    input  MOSI,
    input  tx_data,
    input  tx_valid,
    output MISO,
    output rx_data,
    output rx_valid
  );

  modport master (
    output SS_n,
    output MOSI,
    output tx_data,
    output tx_valid,
    input  MISO,
    input  rx_data,
    input  rx_valid
  );

endinterface

// File: rtl/spi_slave_if.sv
// SPI slave front end: turns each SS_n-framed serial transfer into a
// {cmd, payload} word strobed to the RAM, and shifts read responses back
// out on MISO. clk is the SPI bit clock, one bit per cycle.
module spi_slave_if
  import spi_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_slave_if_if.slave   bus
);

  localparam int CNT_W = $clog2(FRAME_BITS);
  localparam int OUT_W = $clog2(DATA_WIDTH + 1);

  state_t                state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH:0]   shift_in;
  logic                  frame_done;
  logic                  wait_tx;
  logic [DATA_WIDTH-1:0] out_shift;
  logic [OUT_W-1:0]      out_cnt;
  logic                  miso_q;
  logic [DATA_WIDTH+1:0] rx_data_q;
  logic                  rx_valid_q;
  logic                  rd_addr_flag;

  assign bus.MISO     = miso_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

  // Frame FSM: selector decode, 10-bit shift-in, strobe, and read-data shift-out
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift_in     <= '0;
      frame_done   <= 1'b0;
      wait_tx      <= 1'b0;
      out_shift    <= '0;
      out_cnt      <= '0;
      miso_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rd_addr_flag <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (bus.SS_n) begin
        state      <= IDLE;
        bit_cnt    <= '0;
        frame_done <= 1'b0;
        wait_tx    <= 1'b0;
        out_shift  <= '0;
        out_cnt    <= '0;
        miso_q     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state      <= CHK_CMD;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
            wait_tx    <= 1'b0;
            miso_q     <= 1'b0;
          end
          CHK_CMD: begin
            bit_cnt    <= '0;
            frame_done <= 1'b0;
            if (!bus.MOSI)
              state <= WRITE;
            else if (!rd_addr_flag)
              state <= READ_ADD;
            else
              state <= READ_DATA;
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (!frame_done) begin
              shift_in <= {shift_in[DATA_WIDTH-1:0], bus.MOSI};
              if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                rx_data_q  <= {shift_in, bus.MOSI};
                rx_valid_q <= 1'b1;
                frame_done <= 1'b1;
                bit_cnt    <= '0;
                if (state == READ_ADD)
                  rd_addr_flag <= 1'b1;
                if (state == READ_DATA) begin
                  rd_addr_flag <= 1'b0;
                  wait_tx      <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else if (wait_tx) begin
              if (bus.tx_valid) begin
                miso_q    <= bus.tx_data[DATA_WIDTH-1];
                out_shift <= {bus.tx_data[DATA_WIDTH-2:0], 1'b0};
                out_cnt   <= OUT_W'(DATA_WIDTH - 1);
                wait_tx   <= 1'b0;
              end
            end else if (out_cnt != '0) begin
              miso_q    <= out_shift[DATA_WIDTH-1];
              out_shift <= {out_shift[DATA_WIDTH-2:0], 1'b0};
              out_cnt   <= out_cnt - 1'b1;
            end else begin
              miso_q <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// Self-checking bench for spi_slave_if. The bench plays the SPI master and
// the RAM; a frame-level model predicts strobe cycle, command word and the
// MISO byte from the frame timing rules, and a small RAM model supplies reads.
module tb_spi_slave_if;
  import spi_slave_pkg::*;

  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit         model_flag;
  logic [9:0] last_rx;
  logic [7:0] mem [256];
  logic [7:0] wr_addr;
  logic [7:0] rd_addr;

  spi_slave_if_if #(.DATA_WIDTH(DW)) bus ();

  spi_slave_if #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Hold reset for two cycles with random pin activity, then release idle
  task automatic applyReset();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.SS_n     = 1'($urandom);
      bus.MOSI     = 1'($urandom);
      bus.tx_valid = 1'($urandom);
      bus.tx_data  = 8'($urandom);
      @(posedge clk);
      #1;
      checkOutput("rst_miso", 16'(bus.MISO), 16'h0);
      checkOutput("rst_rx_valid", 16'(bus.rx_valid), 16'h0);
      checkOutput("rst_rx_data", 16'(bus.rx_data), 16'h0);
    end
    model_flag = 1'b0;
    last_rx    = '0;
    @(negedge clk);
    rst_n        = 1'b1;
    bus.SS_n     = 1'b1;
    bus.tx_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle_miso", 16'(bus.MISO), 16'h0);
    checkOutput("idle_rx_valid", 16'(bus.rx_valid), 16'h0);
  endtask

  // One SS_n-framed transfer. Edge k is the k-th posedge with SS_n low at
  // edge 0; outputs seen just after edge k are the cycle k+1 values.
  // abort_bits >= 0 raises SS_n after that many frame bits.
  task automatic applyStimulus(input bit sel, input logic [9:0] word, input int abort_bits,
                               input int extra, input int tx_delay, input bit stray);
    bit         complete;
    bit         rd_data;
    int         last_low;
    int         tx_edge;
    int         c;
    logic [7:0] tx_byte;
    logic       exp_miso;

    complete = (abort_bits < 0);
    rd_data  = sel && model_flag;
    tx_byte  = mem[rd_addr];
    tx_edge  = (rd_data && complete) ? 13 + tx_delay : -1;
    if (!complete)
      last_low = 1 + abort_bits;
    else if (rd_data)
      last_low = tx_edge + 8 + extra;
    else
      last_low = 11 + extra;

    for (int k = 0; k <= last_low + 2; k++) begin
      @(negedge clk);
      bus.SS_n = (k <= last_low) ? 1'b0 : 1'b1;
      if (k == 1)
        bus.MOSI = sel;
      else if (k >= 2 && k <= 11)
        bus.MOSI = word[11-k];
      else
        bus.MOSI = 1'($urandom);
      if (k == tx_edge) begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = tx_byte;
      end else if (stray && k >= 2 && k <= 10 && ($urandom % 3) == 0) begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'($urandom);
      end else begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'($urandom);
      end
      @(posedge clk);
      #1;
      c = k + 1;
      if (complete && c == 12)
        last_rx = word;
      exp_miso = 1'b0;
      if (tx_edge >= 0 && c > tx_edge && c <= tx_edge + 8)
        exp_miso = tx_byte[7-(c-tx_edge-1)];
      checkOutput("rx_valid", 16'(bus.rx_valid), 16'(complete && c == 12));
      checkOutput("miso", 16'(bus.MISO), 16'(exp_miso));
      checkOutput("rx_data", 16'(bus.rx_data), 16'(last_rx));
    end

    if (complete) begin
      if (sel && !model_flag)
        model_flag = 1'b1;
      else if (sel && model_flag)
        model_flag = 1'b0;
      case (word[9:8])
        CMD_WR_ADDR: wr_addr = word[7:0];
        CMD_WR_DATA: mem[wr_addr] = word[7:0];
        CMD_RD_ADDR: rd_addr = word[7:0];
        default: ;
      endcase
    end
  endtask

  initial begin
    bit         sel;
    logic [1:0] cmd;
    int         abort;

    for (int i = 0; i < 256; i++)
      mem[i] = 8'h00;
    wr_addr      = 8'h00;
    rd_addr      = 8'h00;
    model_flag   = 1'b0;
    last_rx      = '0;
    rst_n        = 1'b0;
    bus.SS_n     = 1'b1;
    bus.MOSI     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;

    applyReset();

    $display("[TB] directed frames");
    applyStimulus(1'b0, {CMD_WR_ADDR, 8'h3C}, -1, 0, 0, 1'b0);
    applyStimulus(1'b0, {CMD_WR_DATA, 8'hA5}, -1, 2, 0, 1'b0);
    applyStimulus(1'b1, {CMD_RD_ADDR, 8'h3C}, -1, 0, 0, 1'b0);
    applyStimulus(1'b1, {CMD_RD_DATA, 8'h00}, -1, 0, 0, 1'b0);
    applyStimulus(1'b0, {CMD_WR_ADDR, 8'h55}, 5, 0, 0, 1'b0);
    applyStimulus(1'b0, {CMD_WR_ADDR, 8'h3C}, -1, 0, 0, 1'b0);
    applyStimulus(1'b0, {CMD_WR_DATA, 8'h77}, -1, 1, 0, 1'b1);
    applyStimulus(1'b1, {CMD_RD_ADDR, 8'h3C}, -1, 0, 0, 1'b0);
    applyStimulus(1'b1, {CMD_RD_DATA, 8'h00}, 9, 0, 0, 1'b0);
    applyStimulus(1'b1, {CMD_RD_DATA, 8'h00}, -1, 1, 2, 1'b1);

    $display("[TB] random frames");
    for (int i = 0; i < 30; i++) begin
      sel = 1'($urandom);
      if (!sel)
        cmd = ($urandom_range(0, 1) != 0) ? CMD_WR_DATA : CMD_WR_ADDR;
      else
        cmd = model_flag ? CMD_RD_DATA : CMD_RD_ADDR;
      abort = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 9)) : -1;
      applyStimulus(sel, {cmd, 8'($urandom)}, abort, int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("[TB] reset clears read-address flag");
    if (!model_flag)
      applyStimulus(1'b1, {CMD_RD_ADDR, 8'h3C}, -1, 0, 0, 1'b0);
    applyReset();
    applyStimulus(1'b1, {CMD_RD_ADDR, 8'h3C}, -1, 0, 0, 1'b0);
    applyStimulus(1'b1, {CMD_RD_DATA, 8'h00}, -1, 0, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
